// File: rtl/sramlike_pkg.sv
// Shared definitions for the sram-like bus: size encodings, responder states,
// counter width and byte-enable derivation.
package sramlike_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AWAIT = 2'd1,
        DWAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic       legal;
        logic [3:0] be;
    } be_t;

    // Lane enables for an access; illegal requests get be=0.
    function automatic be_t calc_be(input logic [1:0] size, input logic [1:0] a);
        be_t r;
        r.legal = 1'b0;
        r.be    = 4'b0000;
        case (size)
            SZ_BYTE: begin
                r.legal = 1'b1;
                r.be    = 4'b0001 << a;
            end
            SZ_HALF: begin
                if (!a[0]) begin
                    r.legal = 1'b1;
                    r.be    = 4'b0011 << a;
                end
            end
            SZ_WORD: begin
                if (a == 2'b00) begin
                    r.legal = 1'b1;
                    r.be    = 4'b1111;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sramlike_bram.sv
// Single-port synchronous RAM, byte write enables, registered read port.
// The read register loads the post-write word so writes echo their result.
module sramlike_bram #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] merged_c;

    always_comb begin
        merged_c = mem[idx_i];
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) merged_c[8*b +: 8] = wdata_i[8*b +: 8];
        end
    end

    // Storage is never reset so program images and completed writes survive rst.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= merged_c;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sramlike_ram_slave.sv
// Sram-like bus responder: one outstanding request, programmable address and
// data latencies, served from an internal byte-writable RAM.
module sramlike_ram_slave
    import sramlike_pkg::*;
#(
    parameter int unsigned AW       = 12,
    parameter int unsigned ADDR_LAT = 0,
    parameter int unsigned DATA_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam bit             ALAT_ZERO = (ADDR_LAT == 0);
    localparam logic [CNT_W-1:0] ALAT_M1 = CNT_W'(ADDR_LAT - 1);
    localparam logic [CNT_W-1:0] DLAT_M1 = CNT_W'(DATA_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             data_ok_q, data_ok_d;
    logic             err_out_q, err_out_d;
    be_t              dec_c;
    logic             unused_addr_c;

    assign dec_c         = calc_be(size, addr[1:0]);
    assign unused_addr_c = ^addr[31:AW+2];

    // Handshake is combinational so a zero-latency slave accepts in the request cycle.
    assign addr_ok = req & (((state_q == IDLE) & ALAT_ZERO) |
                            ((state_q == AWAIT) & (cnt_q == '0)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (ALAT_ZERO) begin
                        state_d = DWAIT;
                        cnt_d   = DLAT_M1;
                    end else begin
                        state_d = AWAIT;
                        cnt_d   = ALAT_M1;
                    end
                end
            end
            AWAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = DWAIT;
                    cnt_d   = DLAT_M1;
                end
            end
            DWAIT: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (addr_ok) err_d = ~dec_c.legal;
        data_ok_d = (state_d == DWAIT) && (cnt_d == '0);
        err_out_d = data_ok_d & err_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            data_ok_q <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            data_ok_q <= data_ok_d;
            err_out_q <= err_out_d;
        end
    end

    // A handshake coinciding with rst must not touch the RAM.
    sramlike_bram #(.AW(AW)) u_bram (
        .clk     (clk),
        .rst     (rst),
        .en_i    (addr_ok & ~rst),
        .we_i    (wr ? dec_c.be : 4'b0000),
        .idx_i   (addr[AW+1:2]),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    assign data_ok = data_ok_q;
    assign err     = err_out_q;

endmodule

// File: tb/tb_sramlike_ram_slave.sv
// Directed bench for sramlike_ram_slave in three latency configurations.
module tb_sramlike_ram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  wr  = '0;
    logic [1:0]  size  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  addr_ok, data_ok, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sramlike_ram_slave #(.AW(12), .ADDR_LAT(0), .DATA_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .size(size[0]),
        .addr(addr[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]),
        .data_ok(data_ok[0]), .rdata(rdata[0]), .err(err[0]));

    sramlike_ram_slave #(.AW(12), .ADDR_LAT(3), .DATA_LAT(4)) dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .size(size[1]),
        .addr(addr[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]),
        .data_ok(data_ok[1]), .rdata(rdata[1]), .err(err[1]));

    sramlike_ram_slave #(.AW(12), .ADDR_LAT(2), .DATA_LAT(1)) dut2 (
        .clk(clk), .rst(rst), .req(req[2]), .wr(wr[2]), .size(size[2]),
        .addr(addr[2]), .wdata(wdata[2]), .addr_ok(addr_ok[2]),
        .data_ok(data_ok[2]), .rdata(rdata[2]), .err(err[2]));

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_err;
        logic [31:0] e_rd;
        bit          c_rd;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full transaction on DUT d; req is held until data_ok to probe addr_ok in DWAIT.
    task automatic xact(input int d, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rd, input bit c_rd,
                        input int alat, input int dlat);
        int n;
        bit aok;
        @(negedge clk);
        req[d] = 1'b1; wr[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd;
        #1;
        n = 0;
        while (addr_ok[d] !== 1'b1 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk($sformatf("addr_lat d%0d a=%h", d, a), 32'(n), 32'(alat));
        n = 0;
        aok = 1'b0;
        do begin
            @(negedge clk); #1; n++;
            if (addr_ok[d] === 1'b1) aok = 1'b1;
        end while (data_ok[d] !== 1'b1 && n < 40);
        chk($sformatf("data_lat d%0d a=%h", d, a), 32'(n), 32'(dlat));
        chk($sformatf("addr_ok_in_dwait d%0d", d), 32'(aok), 32'd0);
        chk($sformatf("err d%0d a=%h", d, a), 32'(err[d]), 32'(e_err));
        if (c_rd) chk($sformatf("rdata d%0d a=%h", d, a), rdata[d], e_rd);
        req[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;
        for (int i = 0; i < 3; i++) begin
            size[i] = 2'd0; addr[i] = '0; wdata[i] = '0;
        end

        tv.push_back('{1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b1});
        tv.push_back('{1'b0, 2'd2, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b1});
        tv.push_back('{1'b1, 2'd2, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h1122_3344, 1'b1});
        tv.push_back('{1'b1, 2'd0, 32'h0000_0013, 32'hAA00_0000, 1'b0, 32'hAA22_3344, 1'b1});
        tv.push_back('{1'b0, 2'd2, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hAA22_3344, 1'b1});
        tv.push_back('{1'b0, 2'd2, 32'h0000_4010, 32'h0000_0000, 1'b0, 32'hAA22_3344, 1'b1});
        tv.push_back('{1'b1, 2'd2, 32'h0000_0020, 32'h5566_7788, 1'b0, 32'h5566_7788, 1'b1});
        tv.push_back('{1'b1, 2'd1, 32'h0000_0021, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b0});
        tv.push_back('{1'b0, 2'd2, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h5566_7788, 1'b1});
        tv.push_back('{1'b0, 2'd3, 32'h0000_0020, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0});
        tv.push_back('{1'b0, 2'd2, 32'h0000_0022, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0});
        tv.push_back('{1'b1, 2'd1, 32'h0000_0022, 32'hBEEF_0000, 1'b0, 32'hBEEF_7788, 1'b1});
        tv.push_back('{1'b1, 2'd0, 32'h0000_0020, 32'h0000_0011, 1'b0, 32'hBEEF_7711, 1'b1});
        tv.push_back('{1'b0, 2'd2, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'hBEEF_7711, 1'b1});

        // Reset state of all three instances
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst data_ok d%0d", i), 32'(data_ok[i]), 32'd0);
            chk($sformatf("rst err d%0d", i),     32'(err[i]),     32'd0);
            chk($sformatf("rst rdata d%0d", i),   rdata[i],        32'd0);
            chk($sformatf("rst addr_ok d%0d", i), 32'(addr_ok[i]), 32'd0);
        end

        // Minimum-latency vectors
        foreach (tv[i])
            xact(0, tv[i].w, tv[i].sz, tv[i].a, tv[i].wd, tv[i].e_err, tv[i].e_rd, tv[i].c_rd, 0, 1);

        // Back-to-back: addr_ok low in the data_ok cycle, high the cycle after
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b0; size[0] = 2'd2; addr[0] = 32'h10;
        #1; chk("b2b first addr_ok", 32'(addr_ok[0]), 32'd1);
        @(negedge clk); #1;
        chk("b2b data_ok", 32'(data_ok[0]), 32'd1);
        chk("b2b addr_ok during data_ok", 32'(addr_ok[0]), 32'd0);
        chk("b2b rdata 0x10", rdata[0], 32'hAA22_3344);
        @(negedge clk);
        addr[0] = 32'h20;
        #1;
        chk("b2b second addr_ok", 32'(addr_ok[0]), 32'd1);
        chk("b2b data_ok drops", 32'(data_ok[0]), 32'd0);
        @(negedge clk); #1;
        chk("b2b second data_ok", 32'(data_ok[0]), 32'd1);
        chk("b2b rdata 0x20", rdata[0], 32'hBEEF_7711);
        req[0] = 1'b0;

        // Handshake coinciding with rst writes nothing
        @(negedge clk);
        rst = 1'b1; req[0] = 1'b1; wr[0] = 1'b1; size[0] = 2'd2;
        addr[0] = 32'h10; wdata[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        rst = 1'b0; req[0] = 1'b0;
        #1;
        chk("rst-hs data_ok", 32'(data_ok[0]), 32'd0);
        chk("rst-hs rdata", rdata[0], 32'd0);
        xact(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, 32'hAA22_3344, 1'b1, 0, 1);

        // Long latencies
        xact(1, 1'b1, 2'd2, 32'h08, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b1, 3, 4);
        xact(1, 1'b0, 2'd2, 32'h08, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b1, 3, 4);
        xact(1, 1'b1, 2'd1, 32'h0A, 32'h1234_0000, 1'b0, 32'h1234_F00D, 1'b1, 3, 4);
        xact(1, 1'b0, 2'd1, 32'h0B, 32'h0,         1'b1, 32'h0,         1'b0, 3, 4);

        // rst during DWAIT of a write to 0x40
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b1; size[1] = 2'd2; addr[1] = 32'h40; wdata[1] = 32'hA5A5_F00F;
        #1;
        n = 0;
        while (addr_ok[1] !== 1'b1 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk("rst-dwait addr_lat", 32'(n), 32'd3);
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst-dwait data_ok", 32'(data_ok[1]), 32'd0);
        chk("rst-dwait err",     32'(err[1]),     32'd0);
        chk("rst-dwait rdata",   rdata[1],        32'd0);
        chk("rst-dwait addr_ok", 32'(addr_ok[1]), 32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
            if (data_ok[1] !== 1'b0) seen = 1'b1;
        end
        chk("rst-dwait late data_ok", 32'(seen), 32'd0);
        xact(1, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, 32'hA5A5_F00F, 1'b1, 3, 4);

        // Withdrawn request during AWAIT
        xact(2, 1'b1, 2'd2, 32'h04, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1, 2, 1);
        @(negedge clk);
        req[2] = 1'b1; wr[2] = 1'b1; size[2] = 2'd2; addr[2] = 32'h04; wdata[2] = 32'hFFFF_FFFF;
        #1;
        chk("withdraw addr_ok c0", 32'(addr_ok[2]), 32'd0);
        @(negedge clk);
        #1;
        chk("withdraw addr_ok c1", 32'(addr_ok[2]), 32'd0);
        req[2] = 1'b0;
        #1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
            if (addr_ok[2] !== 1'b0 || data_ok[2] !== 1'b0) seen = 1'b1;
        end
        chk("withdraw no response", 32'(seen), 32'd0);
        xact(2, 1'b0, 2'd2, 32'h04, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
